stream_mux: RTL and testbench

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/stream_mux_if.sv | 31 +++
 rtl/stream_mux_rr_arbiter.sv | 37 +++
 rtl/stream_mux.sv | 98 +++++++++
 tb/tb_stream_mux.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and default sizing for the packet-aware stream multiplexer.
package stream_mux_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/stream_mux_if.sv
// Per-channel input streams and the single merged output stream.
interface stream_mux_if
    import stream_mux_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) ();

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [SW-1:0]  out_sel;
    logic           out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Picks the first requesting channel from the pointer (round-robin)
// or from channel 0 (fixed priority); grant is one-hot.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = $clog2(DEF_N)
) (
    input  logic [N-1:0]  request,
    input  logic [SW-1:0] pointer,
    input  logic          fixed,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] index,
    output logic          any
);

    int   c;
    logic found;

    always_comb begin
        grant = '0;
        index = '0;
        any   = |request;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = fixed ? k : int'(pointer) + k;
            if (c >= N) c = c - N;
            if (!found && request[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                index    = SW'(c);
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer that keeps packets whole; one registered
// output stage gives one-cycle latency and full throughput.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int W          = DEF_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic   clk,
    input  logic   rst,
    stream_mux_if.slave bus
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    state_e        state;
    logic [SW-1:0] lock_ch;
    logic [SW-1:0] ptr;

    logic [N-1:0]  grant;
    logic [SW-1:0] win;
    logic          any;

    logic          slot_free;
    logic          idle;
    logic          accept;
    logic          last;
    logic [SW-1:0] sel;
    logic [N-1:0]  rdy;

    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          o_last;
    logic [SW-1:0] o_sel;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .request (bus.in_valid),
        .pointer (ptr),
        .fixed   (FIXED_PRIO != 0),
        .grant   (grant),
        .index   (win),
        .any     (any)
    );

    always_comb begin
        slot_free = !o_valid || bus.out_ready;
        idle      = (state == IDLE);
        sel       = idle ? win : lock_ch;
        last      = bus.in_last[sel];
        accept    = slot_free && (idle ? any : bus.in_valid[lock_ch]);
        rdy       = '0;
        // A locked owner is offered the slot even while it bubbles
        if (!rst && slot_free)
            rdy = idle ? grant : (N'(1) << lock_ch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
            ptr     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_sel   <= '0;
        end else begin
            if (accept) begin
                o_valid <= 1'b1;
                o_data  <= bus.in_data[int'(sel)*W +: W];
                o_last  <= last;
                o_sel   <= sel;
            end else if (slot_free) begin
                o_valid <= 1'b0;
            end
            if (accept) begin
                if (last) begin
                    state <= IDLE;
                    ptr   <= (sel == LAST_CH) ? '0 : sel + SW'(1);
                end else if (idle) begin
                    state   <= LOCKED;
                    lock_ch <= sel;
                end
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = o_data;
    assign bus.out_valid = o_valid;
    assign bus.out_last  = o_last;
    assign bus.out_sel   = o_sel;

endmodule

// File: tb/tb_stream_mux.sv
// Directed scenarios plus a randomized run against a packet-level model.
module tb_stream_mux;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    stream_mux_if #(.N(N), .W(W)) bus ();

    stream_mux #(
        .N          (N),
        .W          (W),
        .FIXED_PRIO (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic set_ch(input int c, input logic v,
                          input logic [W-1:0] d, input logic l);
        bus.in_valid[c]        = v;
        bus.in_data[c*W +: W]  = d;
        bus.in_last[c]         = l;
    endtask

    task automatic clear_all();
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_last  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL rst_ready: got %b expected 0000", bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_all();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 ||
            bus.out_sel !== 2'd0 || bus.out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: got v%b d%h s%0d l%b expected v0 d0 s0 l0",
                     bus.out_valid, bus.out_data, bus.out_sel, bus.out_last);
        end
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 0000", bus.in_ready);
        end
    endtask

    task automatic test_single_beat();
        @(posedge clk); #1;
        set_ch(2, 1'b1, 4'hA, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_ready: got %b expected 0100", bus.in_ready);
        end
        @(posedge clk); #1;
        set_ch(2, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA ||
            bus.out_sel !== 2'd2 || bus.out_last !== 1'b1) begin
            fails++;
            $display("FAIL single_out: got v%b d%h s%0d l%b expected v1 dA s2 l1",
                     bus.out_valid, bus.out_data, bus.out_sel, bus.out_last);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drop: got out_valid %b expected 0", bus.out_valid);
        end
    endtask

    // Pointer sits at 3 after the single-beat test on channel 2
    task automatic test_rr_wrap();
        int ord[4] = '{3, 0, 1, 2};
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) set_ch(c, 1'b1, 4'(4 + c), 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 4'(1 << ord[i])) begin
                fails++;
                $display("FAIL rr_ready[%0d]: got %b expected %b",
                         i, bus.in_ready, 4'(1 << ord[i]));
            end
            if (i > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(ord[i-1]) ||
                    bus.out_data !== 4'(4 + ord[i-1])) begin
                    fails++;
                    $display("FAIL rr_out[%0d]: got v%b s%0d d%h expected v1 s%0d d%h",
                             i, bus.out_valid, bus.out_sel, bus.out_data,
                             ord[i-1], 4'(4 + ord[i-1]));
                end
            end
            @(posedge clk); #1;
            set_ch(ord[i], 1'b0, 4'h0, 1'b0);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 ||
            bus.out_data !== 4'h6) begin
            fails++;
            $display("FAIL rr_out_last: got v%b s%0d d%h expected v1 s2 d6",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_lock();
        @(posedge clk); #1;
        set_ch(0, 1'b1, 4'hF, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            fails++;
            $display("FAIL lock_pre: got %b expected 0001", bus.in_ready);
        end
        @(posedge clk); #1;
        set_ch(0, 1'b1, 4'h9, 1'b1);
        set_ch(1, 1'b1, 4'h1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 4'b0010) begin
                fails++;
                $display("FAIL lock_ready[%0d]: got %b expected 0010", j, bus.in_ready);
            end
            if (j > 0) begin
                checks++;
                if (bus.out_sel !== 2'd1 || bus.out_data !== 4'(j) ||
                    bus.out_last !== 1'b0) begin
                    fails++;
                    $display("FAIL lock_out[%0d]: got s%0d d%h l%b expected s1 d%h l0",
                             j, bus.out_sel, bus.out_data, bus.out_last, 4'(j));
                end
            end
            @(posedge clk); #1;
            if (j < 2) set_ch(1, 1'b1, 4'(j + 2), j == 1);
            else       set_ch(1, 1'b0, 4'h0, 1'b0);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 4'b0001 || bus.out_sel !== 2'd1 ||
            bus.out_data !== 4'h3 || bus.out_last !== 1'b1) begin
            fails++;
            $display("FAIL lock_release: got r%b s%0d d%h l%b expected r0001 s1 d3 l1",
                     bus.in_ready, bus.out_sel, bus.out_data, bus.out_last);
        end
        @(posedge clk); #1;
        set_ch(0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 4'h9) begin
            fails++;
            $display("FAIL lock_after: got s%0d d%h expected s0 d9",
                     bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        set_ch(3, 1'b1, 4'hC, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 4'b1000) begin
            fails++;
            $display("FAIL bp_ready: got %b expected 1000", bus.in_ready);
        end
        @(posedge clk); #1;
        set_ch(3, 1'b0, 4'h0, 1'b0);
        set_ch(2, 1'b1, 4'h5, 1'b1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hC ||
                bus.in_ready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v%b d%h r%b expected v1 dC r0000",
                         k, bus.out_valid, bus.out_data, bus.in_ready);
            end
            @(posedge clk); #1;
            if (k == 2) bus.out_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bus.out_data !== 4'hC || bus.in_ready !== 4'b0100) begin
            fails++;
            $display("FAIL bp_resume: got d%h r%b expected dC r0100",
                     bus.out_data, bus.in_ready);
        end
        @(posedge clk); #1;
        set_ch(2, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h5 ||
            bus.out_sel !== 2'd2) begin
            fails++;
            $display("FAIL bp_next: got v%b d%h s%0d expected v1 d5 s2",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_dup: got out_valid %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        @(posedge clk); #1;
        set_ch(1, 1'b1, 4'h1, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 4'b0010) begin
            fails++;
            $display("FAIL rmid_b1: got %b expected 0010", bus.in_ready);
        end
        @(posedge clk); #1;
        set_ch(1, 1'b1, 4'h2, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        set_ch(1, 1'b1, 4'h3, 1'b1);
        set_ch(0, 1'b1, 4'h7, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 4'h0 || bus.out_sel !== 2'd0 ||
            bus.out_last !== 1'b0) begin
            fails++;
            $display("FAIL rmid_reset: got r%b v%b d%h s%0d l%b expected all 0",
                     bus.in_ready, bus.out_valid, bus.out_data,
                     bus.out_sel, bus.out_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            fails++;
            $display("FAIL rmid_grant: got %b expected 0001", bus.in_ready);
        end
        @(posedge clk); #1;
        set_ch(0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 4'h7 ||
            bus.in_ready !== 4'b0010) begin
            fails++;
            $display("FAIL rmid_after: got s%0d d%h r%b expected s0 d7 r0010",
                     bus.out_sel, bus.out_data, bus.in_ready);
        end
        @(posedge clk); #1;
        set_ch(1, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
    endtask

    // Model: owner channel (or none), rr pointer, output-slot occupancy,
    // and a FIFO of accepted beats in acceptance order.
    task automatic test_random(input int cycles);
        int          p = 0;
        int          owner = -1;
        bit          m_ov = 0;
        bit          sf;
        int          g;
        int          rem[N];
        logic [6:0]  q[$];
        logic [6:0]  b;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] acc;
        rst = 1'b1;
        clear_all();
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < N; c++) rem[c] = 0;
        for (int cyc = 0; cyc < cycles + 20; cyc++) begin
            @(negedge clk);
            sf = !m_ov || bus.out_ready;
            exp_rdy = '0;
            if (sf && owner >= 0) begin
                exp_rdy[owner] = 1'b1;
            end else if (sf) begin
                for (int k = 0; k < N; k++) begin
                    g = (p + k) % N;
                    if (bus.in_valid[g]) begin
                        exp_rdy[g] = 1'b1;
                        break;
                    end
                end
            end
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rand_ready@%0d: got %b expected %b",
                         cyc, bus.in_ready, exp_rdy);
            end
            checks++;
            if (bus.out_valid !== m_ov) begin
                fails++;
                $display("FAIL rand_valid@%0d: got %b expected %b",
                         cyc, bus.out_valid, m_ov);
            end
            if (m_ov && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_beat@%0d: got a beat expected none", cyc);
                end else begin
                    b = q.pop_front();
                    if ({bus.out_sel, bus.out_last, bus.out_data} !== b) begin
                        fails++;
                        $display("FAIL rand_beat@%0d: got s%0d l%b d%h expected s%0d l%b d%h",
                                 cyc, bus.out_sel, bus.out_last, bus.out_data,
                                 b[6:5], b[4], b[3:0]);
                    end
                end
            end
            acc = exp_rdy & bus.in_valid;
            if (acc != '0) begin
                g = 0;
                for (int k = 0; k < N; k++) if (acc[k]) g = k;
                q.push_back({2'(g), bus.in_last[g], bus.in_data[g*W +: W]});
                if (bus.in_last[g]) begin
                    p = (g + 1) % N;
                    owner = -1;
                end else begin
                    owner = g;
                end
                m_ov = 1;
            end else if (sf) begin
                m_ov = 0;
            end
            @(posedge clk); #1;
            bus.out_ready = (cyc >= cycles) || (($urandom % 4) != 0);
            for (int c = 0; c < N; c++) begin
                if (acc[c]) begin
                    rem[c]--;
                    bus.in_valid[c] = 1'b0;
                end
                if (cyc < cycles && !bus.in_valid[c] && ($urandom % 3) == 0) begin
                    if (rem[c] == 0) rem[c] = $urandom_range(1, 3);
                    set_ch(c, 1'b1, 4'($urandom), rem[c] == 1);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL rand_drain: got %0d beats pending expected 0", q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        clear_all();
        test_reset();
        test_single_beat();
        test_rr_wrap();
        test_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
